// File: rtl/dbi_tx_phy.sv
// MIPI DBI type-B (8080-style) write-only transmit PHY: serialises handshaked
// bytes onto CSX/DCX/WRX/D with programmable WRX low/high times.
module dbi_tx_phy #(
  parameter int DBI_IF_D_W  = 8,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_i,
  input  logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_i,
  input  logic                  dtp_tx_last_i,
  input  logic                  dtp_tx_vld_i,
  output logic                  dtp_tx_rdy_o,
  output logic                  dbi_csx_o,
  output logic                  dbi_dcx_o,
  output logic                  dbi_wrx_o,
  output logic                  dbi_rdx_o,
  output logic [DBI_IF_D_W-1:0] dbi_d_o
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    WR_LOW,
    WR_HIGH,
    CS_HOLD
  } state_t;

  localparam logic [3:0] LOW_LAST  = 4'(WR_LOW_CYC - 1);
  localparam logic [3:0] HIGH_LAST = 4'(WR_HIGH_CYC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       last_q;
  logic       rdy_dec;
  logic       hs;

  always_comb begin
    rdy_dec = 1'b0;
    case (state)
      IDLE:    rdy_dec = 1'b1;
      WR_HIGH: rdy_dec = (cnt == HIGH_LAST) && !last_q;
      default: rdy_dec = 1'b0;
    endcase
  end

  // Reset forces rdy low immediately so no byte is accepted while held in reset.
  assign dtp_tx_rdy_o = rdy_dec & ~rst;
  assign hs           = dtp_tx_vld_i & dtp_tx_rdy_o;
  assign dbi_rdx_o    = 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (hs) state_nxt = CS_SETUP;
      CS_SETUP: state_nxt = WR_LOW;
      WR_LOW:   if (cnt == LOW_LAST) state_nxt = WR_HIGH;
      WR_HIGH: begin
        if (cnt == HIGH_LAST) begin
          if (last_q)  state_nxt = CS_HOLD;
          else if (hs) state_nxt = WR_LOW;
        end
      end
      CS_HOLD:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Counter restarts on each state entry; it parks at HIGH_LAST while a
  // streaming frame idles in WR_HIGH so rdy stays asserted.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state)
      cnt_nxt = 4'd0;
    else if (state == WR_HIGH && cnt == HIGH_LAST)
      cnt_nxt = cnt;
    else if (cnt != 4'hF)
      cnt_nxt = cnt + 4'd1;
  end

  // DBI pins are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last_q    <= 1'b0;
      dbi_csx_o <= 1'b1;
      dbi_wrx_o <= 1'b1;
      dbi_dcx_o <= 1'b1;
      dbi_d_o   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dbi_csx_o <= (state_nxt == IDLE);
      dbi_wrx_o <= (state_nxt != WR_LOW);
      if (hs) begin
        last_q    <= dtp_tx_last_i;
        dbi_dcx_o <= |dtp_tx_cmd_typ_i;
        dbi_d_o   <= dtp_tx_cmd_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_dbi_tx_phy.sv
// Directed bench for dbi_tx_phy: per-cycle vector table plus a streaming
// frame sequence checked edge by edge.
module tb_dbi_tx_phy;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] typ;
  logic [7:0] dat;
  logic       last;
  logic       vld;
  logic       rdy;
  logic       csx;
  logic       dcx;
  logic       wrx;
  logic       rdx;
  logic [7:0] d;

  int n_vec  = 0;
  int n_fail = 0;

  dbi_tx_phy #(
    .DBI_IF_D_W (8),
    .WR_LOW_CYC (2),
    .WR_HIGH_CYC(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dtp_tx_cmd_typ_i(typ),
    .dtp_tx_cmd_dat_i(dat),
    .dtp_tx_last_i   (last),
    .dtp_tx_vld_i    (vld),
    .dtp_tx_rdy_o    (rdy),
    .dbi_csx_o       (csx),
    .dbi_dcx_o       (dcx),
    .dbi_wrx_o       (wrx),
    .dbi_rdx_o       (rdx),
    .dbi_d_o         (d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] typ;
    logic [7:0] dat;
    logic       last;
    logic       csx;
    logic       dcx;
    logic       wrx;
    logic [7:0] d;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic v, input logic [7:0] t,
                     input logic [7:0] da, input logic l, input logic e_csx,
                     input logic e_dcx, input logic e_wrx, input logic [7:0] e_d,
                     input logic e_rdy);
    vec_t x;
    x.rst = r; x.vld = v; x.typ = t; x.dat = da; x.last = l;
    x.csx = e_csx; x.dcx = e_dcx; x.wrx = e_wrx; x.d = e_d; x.rdy = e_rdy;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic [7:0] s_typ [5] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01};
  logic [7:0] s_dat [5] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'hEF};
  logic       s_last[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int idx, nedges, last_edge;
    logic prev_wrx, started, done;

    //   rst vld typ    dat    lst | csx dcx wrx d      rdy
    row(1, 0, 8'h00, 8'h00, 0,   1, 1, 1, 8'h00, 0);  // held in reset
    row(0, 1, 8'h00, 8'h01, 1,   1, 1, 1, 8'h00, 1);  // single command hs
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 1, 8'h01, 0);  // CS_SETUP
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 8'h01, 0);  // WR_LOW
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 8'h01, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 1, 8'h01, 0);  // WR_HIGH
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 1, 8'h01, 0);
    row(0, 1, 8'h80, 8'hFF, 1,   0, 0, 1, 8'h01, 0);  // CS_HOLD, byte ignored
    row(0, 1, 8'h80, 8'h5A, 1,   1, 0, 1, 8'h01, 1);  // IDLE hs, typ 80
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 1, 8'h5A, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 0, 8'h5A, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 0, 8'h5A, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 1, 8'h5A, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 1, 8'h5A, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 1, 8'h5A, 0);
    row(0, 1, 8'h00, 8'h2A, 0,   1, 1, 1, 8'h5A, 1);  // gap frame first byte
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 1, 8'h2A, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 8'h2A, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 8'h2A, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 1, 8'h2A, 0);
    for (int i = 0; i < 6; i++)
      row(0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h2A, 1);  // waiting in WR_HIGH
    row(0, 1, 8'h01, 8'hEF, 1,   0, 0, 1, 8'h2A, 1);  // hs from WR_HIGH
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 0, 8'hEF, 0);  // straight to WR_LOW
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 0, 8'hEF, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 1, 8'hEF, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 1, 8'hEF, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 1, 1, 8'hEF, 0);
    row(0, 1, 8'h00, 8'h33, 0,   1, 1, 1, 8'hEF, 1);
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 1, 8'h33, 0);
    row(0, 0, 8'h00, 8'h00, 0,   0, 0, 0, 8'h33, 0);
    row(1, 0, 8'h00, 8'h00, 0,   0, 0, 0, 8'h33, 0);  // reset in 2nd WR_LOW
    row(1, 0, 8'h00, 8'h00, 0,   1, 1, 1, 8'h00, 0);
    row(0, 0, 8'h00, 8'h00, 0,   1, 1, 1, 8'h00, 1);  // released
    row(0, 0, 8'h00, 8'h00, 0,   1, 1, 1, 8'h00, 1);
    row(0, 0, 8'h00, 8'h00, 0,   1, 1, 1, 8'h00, 1);

    rst = 1'b1; vld = 1'b0; typ = '0; dat = '0; last = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; vld = tbl[i].vld; typ = tbl[i].typ;
      dat = tbl[i].dat; last = tbl[i].last;
      #1;
      n_vec++;
      if ({csx, dcx, wrx, d, rdy, rdx} !== {tbl[i].csx, tbl[i].dcx, tbl[i].wrx, tbl[i].d, tbl[i].rdy, 1'b1}) begin
        n_fail++;
        $display("FAIL row%0d: got csx=%b dcx=%b wrx=%b d=%h rdy=%b rdx=%b, expected csx=%b dcx=%b wrx=%b d=%h rdy=%b rdx=1",
                 i, csx, dcx, wrx, d, rdy, rdx,
                 tbl[i].csx, tbl[i].dcx, tbl[i].wrx, tbl[i].d, tbl[i].rdy);
      end
    end

    // Streaming frame with vld held high.
    idx = 0; nedges = 0; last_edge = 0;
    prev_wrx = 1'b1; started = 1'b0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if (idx < 5) begin
        vld = 1'b1; typ = s_typ[idx]; dat = s_dat[idx]; last = s_last[idx];
      end else begin
        vld = 1'b0; typ = '0; dat = '0; last = 1'b0;
      end
      #1;
      if (!prev_wrx && wrx) begin
        if (nedges < 5) begin
          chk($sformatf("stream_dcx%0d", nedges), int'(dcx), (nedges == 0) ? 0 : 1);
          chk($sformatf("stream_d%0d", nedges), int'(d), int'(s_dat[nedges]));
        end
        if (nedges > 0)
          chk($sformatf("stream_period%0d", nedges), c - last_edge, 4);
        last_edge = c;
        nedges++;
      end
      prev_wrx = wrx;
      if (!csx) started = 1'b1;
      else if (started) done = 1'b1;
      if (vld && rdy) idx++;
    end
    chk("stream_frame_end", int'(done), 1);
    chk("stream_bytes_taken", idx, 5);
    chk("stream_wrx_edges", nedges, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dbi_tx_phy.md
DBI_TX_PHY -- requirements
Module: dbi_tx_phy

Interface
REQ-001 SHALL have parameter DBI_IF_D_W, default 8, width of the DBI data bus and command byte.
REQ-002 SHALL have parameter WR_LOW_CYC, default 2, number of clk cycles WRX is held low per byte; legal range 1..15.
REQ-003 SHALL have parameter WR_HIGH_CYC, default 2, number of clk cycles WRX is held high per byte; legal range 1..15.
REQ-004 SHALL use one clock and a synchronous, active-high reset; clk and rst are the only clock and reset ports.
REQ-005 clk  input  1  block clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 dtp_tx_cmd_typ_i  input  DBI_IF_D_W  byte type; 8'h00 = command (DCX low); any other value = parameter/pixel data (DCX high).
REQ-008 dtp_tx_cmd_dat_i  input  DBI_IF_D_W  byte to place on the DBI bus.
REQ-009 dtp_tx_last_i  input  1  byte ends the CSX frame.
REQ-010 dtp_tx_vld_i  input  1  byte valid.
REQ-011 dtp_tx_rdy_o  output  1  PHY accepts the byte this cycle when dtp_tx_vld_i is also high.
REQ-012 dbi_csx_o  output  1  chip select, active low.
REQ-013 dbi_dcx_o  output  1  data/command select; 0 = command, 1 = data.
REQ-014 dbi_wrx_o  output  1  write strobe; the panel samples on its rising edge.
REQ-015 dbi_rdx_o  output  1  read strobe; held at 1.
REQ-016 dbi_d_o  output  DBI_IF_D_W  DBI data bus.

Function
REQ-017 A handshake SHALL occur in a cycle where dtp_tx_vld_i and dtp_tx_rdy_o are both 1. On a handshake, typ (as the DCX bit), dat and last SHALL be latched. Inputs in any other cycle SHALL be ignored.
REQ-018 The FSM SHALL have exactly these states: IDLE, CS_SETUP, WR_LOW, WR_HIGH, CS_HOLD.
REQ-019 IDLE outputs: csx=1, wrx=1, rdy=1. A handshake SHALL move the FSM to CS_SETUP.
REQ-020 CS_SETUP lasts 1 cycle and then moves to WR_LOW. Outputs: csx=0, wrx=1, dcx and d driven from the latched byte.
REQ-021 WR_LOW lasts WR_LOW_CYC cycles with wrx=0, then moves to WR_HIGH. dcx and d SHALL stay stable throughout WR_LOW.
REQ-022 WR_HIGH holds wrx=1 and csx=0 for at least WR_HIGH_CYC cycles. rdy SHALL be 0 until the last of those cycles.
REQ-023 From the final WR_HIGH cycle onward, if the latched last=0:
  - rdy SHALL be 1.
  - On a handshake, the new byte SHALL be latched and the FSM SHALL move directly to WR_LOW, with no CS_SETUP.
  - With no handshake, the FSM SHALL stay in WR_HIGH (csx=0, wrx=1, rdy=1) indefinitely.
REQ-024 If the latched last=1, then in the final WR_HIGH cycle rdy SHALL be 0 and the FSM SHALL move to CS_HOLD.
REQ-025 CS_HOLD lasts 1 cycle (csx=0, wrx=1, rdy=0) and then moves to IDLE. This guarantees csx=1 for at least 1 cycle between frames.
REQ-026 Cycle counter width SHALL be 4 bits. The counter SHALL clear on every state entry and never wrap within a state.
REQ-027 dbi_d_o and dbi_dcx_o SHALL change only on the cycle after a handshake, never while wrx=0.
REQ-028 dbi_rdx_o SHALL be constant 1.
REQ-029 All DBI outputs SHALL be registered, with no combinational path from the inputs.
REQ-030 dtp_tx_rdy_o SHALL be decoded from the state and counter only.
REQ-031 Byte period in a streaming frame SHALL be WR_LOW_CYC+WR_HIGH_CYC cycles.

Reset
REQ-032 While rst=1 the outputs SHALL be: csx=1, dcx=1, wrx=1, rdx=1, d=0, rdy=0, FSM=IDLE, latched last=0.
REQ-033 Reset asserted in any state SHALL take effect at the next rising edge and abort the transfer. No further WRX edge SHALL occur.
REQ-034 In the first cycle after rst deasserts, rdy SHALL be 1.

Verification
REQ-035 Single command: handshake at T with typ=8'h00, dat=8'h01, last=1 -> required response:
  - T+1: csx=0, dcx=0, d=8'h01.
  - T+2..T+3: wrx=0.
  - T+4..T+5: wrx=1, rdy=0.
  - T+6: CS_HOLD, csx=0.
  - T+7: csx=1, rdy=1.
REQ-036 Streaming: 8'h2A (typ 00), then data 8'h00, 8'h00, 8'h00, 8'hEF (typ 01, last on 8'hEF), vld held high -> required response:
  - csx low continuously for the whole frame.
  - 5 WRX rising edges, 4 cycles apart.
  - dcx=0 for the first byte, 1 for the rest.
REQ-037 Gap: vld dropped for 6 cycles mid-frame -> required response:
  - FSM waits in WR_HIGH with csx=0, wrx=1, rdy=1.
  - Next byte starts WR_LOW 1 cycle after its handshake.
REQ-038 Reset mid-operation: rst=1 during the second WR_LOW cycle -> required response:
  - Next cycle: csx=1, wrx=1, d=0, rdy=0.
  - After release: rdy=1, and no stray WRX edge.
REQ-039 Typ decoding: typ=8'h80, dat=8'h5A -> dcx=1, d=8'h5A for the whole byte.
REQ-040 Back-to-back frames: second frame vld held high during CS_HOLD -> required response:
  - Handshake occurs in the IDLE cycle, with csx=1 for exactly 1 cycle.
  - CS_SETUP follows in the next cycle.
